// File: rtl/mac_sat_fx.sv
// rtl/mac_sat_fx.sv - pipelined signed fixed-point MAC with round, rescale and saturate
// Stage 1 registers the product, stage 2 accumulates a frame, stage 3 rescales/saturates.
module mac_sat_fx #(
  parameter int SIZE  = 21,
  parameter int FRAC  = 15,
  parameter int TAPS  = 8,
  parameter int ROUND = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [SIZE-1:0] a,
  input  logic signed [SIZE-1:0] b,
  output logic                   out_valid,
  output logic signed [SIZE-1:0] y,
  output logic                   ovf
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = 2 * SIZE;
  localparam int AW = PW + $clog2(TAPS);
  localparam logic signed [AW:0] YMAX = {{(AW + 2 - SIZE){1'b0}}, {(SIZE - 1){1'b1}}};
  localparam logic signed [AW:0] YMIN = {{(AW + 2 - SIZE){1'b1}}, {(SIZE - 1){1'b0}}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [PW-1:0]   p_q, prod;
  logic                   p_first_q, p_last_q, p_valid_q;
  logic signed [AW-1:0]   acc_q, p_ext;
  logic                   acc_done_q;
  logic signed [SIZE-1:0] y_q, y_d;
  logic                   ovf_q, ovf_d, out_valid_q;
  logic signed [AW:0]     rnd_c, acc_x, r;
  logic                   accept, first, last;

  assign accept = in_valid & ~clear;
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CW'(TAPS - 1));
  assign prod   = a * b;
  assign p_ext  = AW'(p_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (accept) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  // Rounding constant is half an output LSB; the extra bit keeps the add from wrapping.
  always_comb begin
    rnd_c = '0;
    if (ROUND != 0) rnd_c[FRAC-1] = 1'b1;
    acc_x = {acc_q[AW-1], acc_q} + rnd_c;
    r     = acc_x >>> FRAC;
    y_d   = r[SIZE-1:0];
    ovf_d = 1'b0;
    if (r > YMAX) begin
      y_d   = {1'b0, {(SIZE - 1){1'b1}}};
      ovf_d = 1'b1;
    end else if (r < YMIN) begin
      y_d   = {1'b1, {(SIZE - 1){1'b0}}};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      p_q         <= '0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_valid_q   <= 1'b0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_valid_q <= accept;
      if (accept) begin
        p_q       <= prod;
        p_first_q <= first;
        p_last_q  <= last;
      end
      // The first-tap tag reloads the accumulator, so frames can abut with no bubble.
      if (p_valid_q) acc_q <= p_first_q ? p_ext : acc_q + p_ext;
      acc_done_q  <= p_valid_q & p_last_q & ~clear;
      out_valid_q <= acc_done_q;
      if (acc_done_q) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_sat_fx.sv
// tb/tb_mac_sat_fx.sv - directed and table-driven bench for mac_sat_fx
module tb_mac_sat_fx;

  logic clk = 1'b0;
  logic reset, clear, in_valid;
  logic signed [20:0] in_a, in_b;
  logic ov4, of4, ov0, of0, ov1, of1;
  logic signed [20:0] y4, y0, y1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_sat_fx #(.SIZE(21), .FRAC(15), .TAPS(4), .ROUND(1)) u_dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(in_a), .b(in_b),
    .out_valid(ov4), .y(y4), .ovf(of4));
  mac_sat_fx #(.SIZE(21), .FRAC(15), .TAPS(4), .ROUND(0)) u_dut4t (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(in_a), .b(in_b),
    .out_valid(ov0), .y(y0), .ovf(of0));
  mac_sat_fx #(.SIZE(21), .FRAC(15), .TAPS(1), .ROUND(1)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(in_a), .b(in_b),
    .out_valid(ov1), .y(y1), .ovf(of1));

  typedef struct {
    int y;
    logic ovf;
    int cyc;
  } res_t;
  res_t q4[$];
  res_t q0[$];

  always @(negedge clk) begin
    if (ov4) q4.push_back('{int'(y4), of4, cyc});
    if (ov0) q0.push_back('{int'(y0), of0, cyc});
  end

  typedef struct {
    int a[4];
    int b[4];
    int gap;
    int y4;
    logic o4;
    int yr0;
    logic or0;
  } vec_t;

  function automatic vec_t mkv(input int a0, b0, a1, b1, a2, b2, a3, b3, gap,
                               input int ey4, input logic eo4, input int eyr0, input logic eor0);
    vec_t v;
    v.a = '{a0, a1, a2, a3};
    v.b = '{b0, b1, b2, b3};
    v.gap = gap;
    v.y4 = ey4;
    v.o4 = eo4;
    v.yr0 = eyr0;
    v.or0 = eor0;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int last_acc;

  task automatic drive(input int av, input int bv, input logic clr);
    in_a = 21'(av);
    in_b = 21'(bv);
    in_valid = 1'b1;
    clear = clr;
    last_acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic run_frame(input string name, input vec_t v);
    q4.delete();
    q0.delete();
    for (int t = 0; t < 4; t++) begin
      drive(v.a[t], v.b[t], 1'b0);
      if (t < 3) repeat (v.gap) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk({name, "_count"}, q4.size(), 1);
    chk({name, "_count_r0"}, q0.size(), 1);
    if (q4.size() >= 1) begin
      chk({name, "_y"}, q4[0].y, v.y4);
      chk({name, "_ovf"}, q4[0].ovf, v.o4);
      chk({name, "_lat"}, q4[0].cyc - last_acc, 2);
    end
    if (q0.size() >= 1) begin
      chk({name, "_y_r0"}, q0[0].y, v.yr0);
      chk({name, "_ovf_r0"}, q0[0].ovf, v.or0);
    end
  endtask

  localparam int NV = 9;
  localparam int NR = 1000;
  vec_t vecs[NV];
  int ey[NR];
  logic eo[NR];
  int acc_a;

  initial begin
    vecs[0] = mkv(32768, 32768, 32768, 32768, 32768, 32768, 32768, 32768, 0, 131072, 0, 131072, 0);
    vecs[1] = mkv(32768, 16384, 32768, 16384, 32768, 16384, 32768, 16384, 0, 65536, 0, 65536, 0);
    vecs[2] = mkv(32768, 16384, 32768, 16384, 32768, 16384, 32768, 16384, 3, 65536, 0, 65536, 0);
    vecs[3] = mkv(491520, 491520, 491520, 491520, 491520, 491520, 491520, 491520, 0,
                  1048575, 1, 1048575, 1);
    vecs[4] = mkv(-491520, 491520, -491520, 491520, -491520, 491520, -491520, 491520, 0,
                  -1048576, 1, -1048576, 1);
    vecs[5] = mkv(1, 16384, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[6] = mkv(-1, 16384, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0);
    vecs[7] = mkv(0, 491520, 0, 491520, 0, 491520, 0, 491520, 0, 0, 0, 0, 0);
    vecs[8] = mkv(32768, 32768, -32768, 16384, 65536, 16384, 0, 0, 2, 49152, 0, 49152, 0);

    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {ov4, ov0, ov1}, 0);
    chk("reset_y", y4, 0);
    chk("reset_ovf", {of4, of0, of1}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Reset lands mid-frame and mid-cycle; outputs must drop without a clock edge.
    q4.delete();
    drive(32768, 32768, 1'b0);
    drive(32768, 32768, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_y", y4, 0);
    chk("async_reset_valid", ov4, 0);
    chk("async_reset_ovf", of4, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame("after_reset", vecs[0]);

    q4.delete();
    drive(98304, 98304, 1'b0);
    drive(98304, 98304, 1'b0);
    drive(32768, 32768, 1'b1);
    for (int t = 0; t < 4; t++) drive(32768, 32768, 1'b0);
    repeat (6) @(negedge clk);
    chk("clear_count", q4.size(), 1);
    if (q4.size() >= 1) begin
      chk("clear_y", q4[0].y, 131072);
      chk("clear_lat", q4[0].cyc - last_acc, 2);
    end

    q4.delete();
    for (int t = 0; t < 4; t++) drive(32768, 32768, 1'b0);
    acc_a = last_acc;
    for (int t = 0; t < 4; t++) drive(32768, -32768, 1'b0);
    repeat (6) @(negedge clk);
    chk("b2b_count", q4.size(), 2);
    if (q4.size() >= 2) begin
      chk("b2b_y_a", q4[0].y, 131072);
      chk("b2b_y_b", q4[1].y, -131072);
      chk("b2b_spacing", q4[1].cyc - q4[0].cyc, 4);
      chk("b2b_lat_a", q4[0].cyc - acc_a, 2);
      chk("b2b_ovf_b", q4[1].ovf, 0);
    end

    // Single-tap instance: continuous random stream against an exact product model.
    for (int j = 0; j < NR + 3; j++) begin
      if (j >= 3) begin
        chk($sformatf("t1_valid_%0d", j - 3), ov1, 1);
        chk($sformatf("t1_yovf_%0d", j - 3), {of1, y1}, {eo[j-3], 21'(ey[j-3])});
      end else begin
        chk($sformatf("t1_idle_%0d", j), ov1, 0);
      end
      if (j < NR) begin
        int ai, bi;
        longint p, r;
        if ($urandom_range(0, 1) == 1) begin
          ai = int'($urandom_range(0, 2097151)) - 1048576;
          bi = int'($urandom_range(0, 2097151)) - 1048576;
        end else begin
          ai = int'($urandom_range(0, 131071)) - 65536;
          bi = int'($urandom_range(0, 131071)) - 65536;
        end
        p = longint'(ai) * longint'(bi);
        r = (p + 64'sd16384) >>> 15;
        if (r > 64'sd1048575) begin
          ey[j] = 1048575;
          eo[j] = 1'b1;
        end else if (r < -64'sd1048576) begin
          ey[j] = -1048576;
          eo[j] = 1'b1;
        end else begin
          ey[j] = int'(r);
          eo[j] = 1'b0;
        end
        in_a = 21'(ai);
        in_b = 21'(bi);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t1_drain", ov1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
